// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter microinstruction op codes, arbiter states
// and the ARBI/ARBOPC command decode used by the microinstruction decoder.
package cpu_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 72;

  localparam logic [3:0] ARBI_NOP   = 4'd0;
  localparam logic [3:0] ARBI_READ  = 4'd1;
  localparam logic [3:0] ARBI_WRITE = 4'd2;
  localparam logic [3:0] ARBI_EXEC  = 4'd3;
  localparam logic [3:0] ARBI_CLEAR = 4'd15;

  localparam logic [1:0] OPC_READ  = 2'd1;
  localparam logic [1:0] OPC_WRITE = 2'd2;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_REQ  = 2'd1;
  localparam logic [1:0] ARB_XFER = 2'd2;
  localparam logic [1:0] ARB_ERR  = 2'd3;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_CLEAR = 2'd3
  } arb_cmd_e;

  // EXEC takes its direction from the low bits of ARBOPC; unknown ARBI is NOP.
  function automatic arb_cmd_e arb_decode(input logic [3:0] arbi, input logic [1:0] opc_lo);
    arb_cmd_e cmd;
    case (arbi)
      ARBI_NOP:   cmd = CMD_NONE;
      ARBI_READ:  cmd = CMD_READ;
      ARBI_WRITE: cmd = CMD_WRITE;
      ARBI_EXEC: begin
        case (opc_lo)
          OPC_READ:  cmd = CMD_READ;
          OPC_WRITE: cmd = CMD_WRITE;
          default:   cmd = CMD_NONE;
        endcase
      end
      ARBI_CLEAR: cmd = CMD_CLEAR;
      default:    cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Common-bus handshake between the arbiter (master) and the memory side (slave).
interface bus_arbiter_if;
  import cpu_pkg::*;

  logic              bus_req;
  logic              bus_gnt;
  logic              bus_cyc;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_err;

  modport master (
    output bus_req, bus_cyc, bus_wr, bus_addr, bus_wdata,
    input  bus_gnt, bus_rdata, bus_ack, bus_err
  );

  modport slave (
    input  bus_req, bus_cyc, bus_wr, bus_addr, bus_wdata,
    output bus_gnt, bus_rdata, bus_ack, bus_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Common-bus arbiter: runs one read or write transfer at a time on behalf of
// the microcode, with a watchdog and a sticky error cleared only by CLEAR.
module bus_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        arbi,
  input  logic [3:0]        opc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdy,
  output logic              err,
  bus_arbiter_if.master     bus
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 32'd1);

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  logic [7:0]        wd_r;
  logic [7:0]        wd_s;
  logic              accept_s;
  logic              rd_done_s;
  logic              busy_s;
  arb_cmd_e          cmd_s;
  logic              opc_unused_s;
  logic              bus_req_r;
  logic              bus_cyc_r;
  logic              bus_wr_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              rdy_r;
  logic              err_r;

  assign cmd_s        = arb_decode(arbi, opc[1:0]);
  assign opc_unused_s = ^opc[3:2];

  // Next state, watchdog and transfer-event decode.
  always_comb begin
    state_s   = state_r;
    wd_s      = wd_r;
    accept_s  = 1'b0;
    rd_done_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if ((cmd_s == CMD_READ) || (cmd_s == CMD_WRITE)) begin
          state_s  = ARB_REQ;
          wd_s     = 8'd0;
          accept_s = 1'b1;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        // A grant on the expiry cycle is too late: there is no completion yet.
        if (wd_r == WD_LAST) begin
          state_s = ARB_ERR;
        end else if (bus.bus_gnt) begin
          state_s = ARB_XFER;
          wd_s    = wd_r + 8'd1;
        end else begin
          wd_s = wd_r + 8'd1;
        end
      end
      ARB_XFER: begin
        if (bus.bus_err) begin
          state_s = ARB_ERR;
        end else if (bus.bus_ack) begin
          state_s   = ARB_IDLE;
          rd_done_s = ~bus_wr_r;
        end else if (wd_r == WD_LAST) begin
          state_s = ARB_ERR;
        end else begin
          wd_s = wd_r + 8'd1;
        end
      end
      ARB_ERR: begin
        if (cmd_s == CMD_CLEAR) begin
          state_s = ARB_IDLE;
        end else begin
          state_s = ARB_ERR;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  assign busy_s = (state_s == ARB_REQ) || (state_s == ARB_XFER);

  // State, watchdog and all outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ARB_IDLE;
      wd_r        <= 8'd0;
      bus_req_r   <= 1'b0;
      bus_cyc_r   <= 1'b0;
      bus_wr_r    <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
      rdata_r     <= '0;
      rdy_r       <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      state_r   <= state_s;
      wd_r      <= wd_s;
      bus_req_r <= busy_s;
      bus_cyc_r <= (state_s == ARB_XFER);
      rdy_r     <= ~busy_s;
      err_r     <= (state_s == ARB_ERR);
      if (accept_s) begin
        bus_addr_r  <= addr;
        bus_wdata_r <= wdata;
        bus_wr_r    <= (cmd_s == CMD_WRITE);
      end
      if (rd_done_s) begin
        rdata_r <= bus.bus_rdata;
      end
    end
  end

  assign bus.bus_req   = bus_req_r;
  assign bus.bus_cyc   = bus_cyc_r;
  assign bus.bus_wr    = bus_wr_r;
  assign bus.bus_addr  = bus_addr_r;
  assign bus.bus_wdata = bus_wdata_r;
  assign rdata         = rdata_r;
  assign rdy           = rdy_r;
  assign err           = err_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// transfers predicted from edge-count rules of grant/ack timing.
module tb_bus_arbiter;
  import cpu_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arbi;
  logic [3:0]  opc;
  logic [20:0] addr;
  logic [71:0] wdata;
  logic [71:0] rdata;
  logic        rdy;
  logic        err;
  logic [71:0] exp_rdata;
  int          checks = 0;
  int          fails  = 0;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .arbi(arbi), .opc(opc), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdy(rdy), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] rnd72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b0; bus.bus_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; arbi = ARBI_NOP; opc = 4'd0; addr = 21'h1FFFFF; wdata = rnd72();
    bus_idle(); bus.bus_rdata = rnd72();
    tick(); tick();
    checks++;
    if ({rdy, err, bus.bus_req, bus.bus_cyc, bus.bus_wr} !== 5'b10000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 10000", {rdy, err, bus.bus_req, bus.bus_cyc, bus.bus_wr});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.bus_addr !== 21'd0 || bus.bus_wdata !== 72'd0 || rdata !== 72'd0 || rdy !== 1'b1) begin
      fails++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h rdy=%b want zeros, rdy 1", bus.bus_addr, bus.bus_wdata, rdata, rdy);
    end
    exp_rdata = 72'd0;
  endtask

  task automatic test_read();
    arbi = ARBI_READ; addr = 21'h12345;
    tick();
    arbi = ARBI_NOP; addr = 21'd0;
    checks++;
    if ({rdy, bus.bus_req, bus.bus_cyc, bus.bus_wr} !== 4'b0100 || bus.bus_addr !== 21'h12345) begin
      fails++; $display("FAIL read_req: ctrl=%b addr=%h want 0100 12345", {rdy, bus.bus_req, bus.bus_cyc, bus.bus_wr}, bus.bus_addr);
    end
    bus.bus_gnt = 1'b1;
    tick();
    checks++;
    if ({rdy, bus.bus_req, bus.bus_cyc} !== 3'b011) begin
      fails++; $display("FAIL read_xfer: got %b want 011", {rdy, bus.bus_req, bus.bus_cyc});
    end
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = 72'hAB_0123456789ABCDEF;
    tick();
    bus.bus_ack = 1'b0; bus.bus_rdata = rnd72();
    exp_rdata = 72'hAB_0123456789ABCDEF;
    checks++;
    if ({rdy, bus.bus_req, bus.bus_cyc} !== 3'b100 || rdata !== exp_rdata) begin
      fails++; $display("FAIL read_done: ctrl=%b rdata=%h want 100 %h", {rdy, bus.bus_req, bus.bus_cyc}, rdata, exp_rdata);
    end
  endtask

  task automatic test_write_delayed_gnt();
    logic [71:0] w;
    w = 72'h5A_FFFF0000FFFF0000;
    arbi = ARBI_WRITE; addr = 21'h0ABCD; wdata = w;
    tick();
    arbi = ARBI_NOP; wdata = rnd72();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rdy, bus.bus_req, bus.bus_cyc, bus.bus_wr} !== 4'b0101 || bus.bus_wdata !== w) begin
        fails++; $display("FAIL write_wait[%0d]: ctrl=%b wdata=%h want 0101 %h", i, {rdy, bus.bus_req, bus.bus_cyc, bus.bus_wr}, bus.bus_wdata, w);
      end
      tick();
    end
    bus.bus_gnt = 1'b1;
    tick();
    checks++;
    if ({rdy, bus.bus_req, bus.bus_cyc, bus.bus_wr} !== 4'b0111 || bus.bus_wdata !== w) begin
      fails++; $display("FAIL write_xfer: ctrl=%b wdata=%h want 0111", {rdy, bus.bus_req, bus.bus_cyc, bus.bus_wr}, bus.bus_wdata);
    end
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b1; bus.bus_rdata = rnd72();
    tick();
    bus_idle();
    checks++;
    if ({rdy, err, bus.bus_req, bus.bus_cyc} !== 4'b1000 || rdata !== exp_rdata) begin
      fails++; $display("FAIL write_done: ctrl=%b rdata=%h want 1000 %h", {rdy, err, bus.bus_req, bus.bus_cyc}, rdata, exp_rdata);
    end
  endtask

  task automatic test_timeout();
    arbi = ARBI_READ; addr = 21'h00777;
    tick();
    arbi = ARBI_NOP;
    for (int k = 1; k <= int'(TO); k++) begin
      tick();
      if (k == int'(TO) - 1) begin
        checks++;
        if ({rdy, err, bus.bus_req} !== 3'b001) begin
          fails++; $display("FAIL timeout_early: got %b want 001", {rdy, err, bus.bus_req});
        end
      end
    end
    checks++;
    if ({rdy, err, bus.bus_req, bus.bus_cyc} !== 4'b1100 || rdata !== exp_rdata) begin
      fails++; $display("FAIL timeout_err: ctrl=%b rdata=%h want 1100", {rdy, err, bus.bus_req, bus.bus_cyc}, rdata);
    end
    arbi = ARBI_READ;
    tick();
    arbi = ARBI_NOP;
    bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0;
    checks++;
    if ({rdy, err, bus.bus_req, bus.bus_cyc} !== 4'b1100) begin
      fails++; $display("FAIL err_ignores_read: got %b want 1100", {rdy, err, bus.bus_req, bus.bus_cyc});
    end
    arbi = ARBI_CLEAR;
    tick();
    arbi = ARBI_NOP;
    checks++;
    if ({rdy, err, bus.bus_req} !== 3'b100) begin
      fails++; $display("FAIL clear_err: got %b want 100", {rdy, err, bus.bus_req});
    end
  endtask

  task automatic test_err_priority();
    arbi = ARBI_READ; addr = 21'h1F00F;
    tick();
    arbi = ARBI_NOP; bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b1; bus.bus_err = 1'b1; bus.bus_rdata = rnd72();
    tick();
    bus_idle();
    checks++;
    if ({rdy, err, bus.bus_req, bus.bus_cyc} !== 4'b1100 || rdata !== exp_rdata) begin
      fails++; $display("FAIL err_priority: ctrl=%b rdata=%h want 1100 %h", {rdy, err, bus.bus_req, bus.bus_cyc}, rdata, exp_rdata);
    end
    arbi = ARBI_CLEAR;
    tick();
    arbi = ARBI_NOP;
    checks++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL err_priority_clear: err=%b want 0", err);
    end
  endtask

  task automatic test_ignore_in_xfer();
    logic [71:0] d;
    d = rnd72();
    arbi = ARBI_READ; addr = 21'h0AAAA;
    tick();
    arbi = ARBI_CLEAR;
    tick();
    checks++;
    if ({rdy, bus.bus_req, bus.bus_cyc} !== 3'b010) begin
      fails++; $display("FAIL clear_in_req: got %b want 010", {rdy, bus.bus_req, bus.bus_cyc});
    end
    arbi = ARBI_NOP; bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0; arbi = ARBI_WRITE; addr = 21'h15555; wdata = rnd72();
    tick();
    arbi = ARBI_NOP;
    checks++;
    if ({bus.bus_cyc, bus.bus_wr} !== 2'b10 || bus.bus_addr !== 21'h0AAAA) begin
      fails++; $display("FAIL write_in_xfer: cyc_wr=%b addr=%h want 10 0aaaa", {bus.bus_cyc, bus.bus_wr}, bus.bus_addr);
    end
    bus.bus_ack = 1'b1; bus.bus_rdata = d;
    tick();
    bus_idle();
    exp_rdata = d;
    tick();
    checks++;
    if ({rdy, bus.bus_req, bus.bus_wr} !== 3'b100 || rdata !== d) begin
      fails++; $display("FAIL single_xfer: ctrl=%b rdata=%h want 100 %h", {rdy, bus.bus_req, bus.bus_wr}, rdata, d);
    end
  endtask

  task automatic test_reset_mid_xfer();
    arbi = ARBI_WRITE; addr = 21'h1ABCD; wdata = rnd72();
    tick();
    arbi = ARBI_NOP; bus.bus_gnt = 1'b1;
    tick();
    bus.bus_gnt = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({rdy, err, bus.bus_req, bus.bus_cyc, bus.bus_wr} !== 5'b10000 || bus.bus_addr !== 21'd0 ||
        bus.bus_wdata !== 72'd0 || rdata !== 72'd0) begin
      fails++; $display("FAIL reset_mid: ctrl=%b addr=%h wdata=%h rdata=%h want 10000 and zeros",
                        {rdy, err, bus.bus_req, bus.bus_cyc, bus.bus_wr}, bus.bus_addr, bus.bus_wdata, rdata);
    end
    bus.bus_ack = 1'b1; bus.bus_rdata = rnd72();
    tick();
    bus_idle();
    exp_rdata = 72'd0;
    checks++;
    if ({rdy, err, bus.bus_req, bus.bus_cyc} !== 4'b1000 || rdata !== 72'd0) begin
      fails++; $display("FAIL late_ack: ctrl=%b rdata=%h want 1000 0", {rdy, err, bus.bus_req, bus.bus_cyc}, rdata);
    end
  endtask

  // Random commands; the outcome edge is predicted from grant/ack delays vs TO.
  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  a_op;
      logic [3:0]  o_op;
      logic [20:0] a;
      logic [71:0] rd;
      int g, ad, kind, e_edge;
      bit is_rd, is_wr, failed;
      case ($urandom_range(0, 5))
        0: a_op = ARBI_READ;
        1: a_op = ARBI_WRITE;
        2, 3: a_op = ARBI_EXEC;
        4: a_op = ARBI_CLEAR;
        default: a_op = 4'($urandom_range(4, 14));
      endcase
      o_op = 4'($urandom); a = 21'($urandom); rd = rnd72();
      g = $urandom_range(0, 18); ad = $urandom_range(0, 6); kind = $urandom_range(0, 2);
      is_rd = (a_op == 4'd1) || (a_op == 4'd3 && o_op % 4 == 1);
      is_wr = (a_op == 4'd2) || (a_op == 4'd3 && o_op % 4 == 2);
      arbi = a_op; opc = o_op; addr = a; wdata = rnd72();
      tick();
      arbi = ARBI_NOP;
      if (!is_rd && !is_wr) begin
        checks++;
        if ({rdy, err, bus.bus_req, bus.bus_cyc} !== 4'b1000) begin
          fails++; $display("FAIL rnd_nop[%0d]: arbi=%0d opc=%0d got %b want 1000", n, a_op, o_op, {rdy, err, bus.bus_req, bus.bus_cyc});
        end
        continue;
      end
      if (g + 1 >= int'(TO)) begin
        e_edge = int'(TO); failed = 1'b1;
      end else if (g + ad + 2 <= int'(TO)) begin
        e_edge = g + ad + 2; failed = (kind != 0);
      end else begin
        e_edge = int'(TO); failed = 1'b1;
      end
      for (int k = 1; k <= e_edge + 1; k++) begin
        bus.bus_gnt   = (k == g + 1);
        bus.bus_ack   = (k == g + ad + 2) && (kind != 1);
        bus.bus_err   = (k == g + ad + 2) && (kind != 0);
        bus.bus_rdata = (k == g + ad + 2) ? rd : rnd72();
        tick();
        checks++;
        if ({rdy, err, bus.bus_req, bus.bus_cyc} !== {k >= e_edge, failed && k >= e_edge, k < e_edge, k >= g + 1 && k < e_edge} ||
            bus.bus_wr !== is_wr || bus.bus_addr !== a) begin
          fails++; $display("FAIL rnd_cycle[%0d.%0d]: g=%0d ad=%0d kind=%0d ctrl=%b wr=%b addr=%h want end %0d wr=%b addr=%h",
                            n, k, g, ad, kind, {rdy, err, bus.bus_req, bus.bus_cyc}, bus.bus_wr, bus.bus_addr, e_edge, is_wr, a);
        end
      end
      bus_idle();
      if (!failed && is_rd) exp_rdata = rd;
      checks++;
      if (rdata !== exp_rdata) begin
        fails++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rdata, exp_rdata);
      end
      if (failed) begin
        arbi = ARBI_CLEAR;
        tick();
        arbi = ARBI_NOP;
        checks++;
        if ({rdy, err} !== 2'b10) begin
          fails++; $display("FAIL rnd_clear[%0d]: got %b want 10", n, {rdy, err});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_delayed_gnt();
    test_timeout();
    test_err_priority();
    test_ignore_in_xfer();
    test_random();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: bus watchdog limit in cycles (8-bit counter).
REQ-002 clk  in  1  clock; one clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 arbi  in  4  operation from microinstruction field ARBI: 0 NOP, 1 READ, 2 WRITE, 3 EXEC (op from opc), 15 CLEAR; others treated as NOP.
REQ-005 opc  in  4  arbiter opcode register ARBOPC; for EXEC, opc[1:0]=1 READ, 2 WRITE, other NOP.
REQ-006 addr  in  21  physical word address {PHYSPG, offset}.
REQ-007 wdata  in  72  write word (64 data + 8 tag).
REQ-008 rdata  out  72  last read word, held until next successful read.
REQ-009 rdy  out  1  ARBRDY to condition mux; 1 = no transfer in progress.
REQ-010 err  out  1  sticky transfer failure (timeout or bus error).
REQ-011 bus_req  out  1  common-bus request.
REQ-012 bus_gnt  in  1  common-bus grant.
REQ-013 bus_cyc  out  1  transfer strobe, valid address/control/data.
REQ-014 bus_wr  out  1  1 = write cycle.
REQ-015 bus_addr  out  21  registered transfer address.
REQ-016 bus_wdata  out  72  registered write data.
REQ-017 bus_rdata  in  72  read data, valid with bus_ack.
REQ-018 bus_ack  in  1  transfer completion.
REQ-019 bus_err  in  1  transfer error, valid in place of bus_ack.

Function
REQ-020 FSM states IDLE, REQ, XFER, ERR; rdy=1 in IDLE and ERR, 0 in REQ and XFER.
REQ-021 IDLE: READ/WRITE (direct or EXEC) latches addr, wdata, direction into bus_addr/bus_wdata/bus_wr and goes to REQ next cycle.
REQ-022 Commands arriving in REQ or XFER are ignored, no queueing.
REQ-023 REQ: bus_req=1; bus_gnt sampled 1 -> XFER next cycle; bus_req stays 1 through XFER.
REQ-024 XFER: bus_cyc=1; bus_ack=1 -> IDLE; for reads rdata <= bus_rdata on that edge.
REQ-025 XFER: bus_err=1 (priority over bus_ack same cycle) -> ERR, rdata unchanged.
REQ-026 Watchdog: cleared on command acceptance, increments each cycle in REQ/XFER; reaching TIMEOUT without completion -> ERR.
REQ-027 Minimum latency: command edge N, gnt sampled edge N+1, ack sampled edge N+2, rdy=1 after edge N+2.
REQ-028 ERR: err=1, bus_req=bus_cyc=0; only CLEAR accepted -> IDLE with err=0; READ/WRITE in ERR ignored.
REQ-029 CLEAR in IDLE: no effect besides err=0; CLEAR in REQ/XFER ignored.
REQ-030 bus_req and bus_cyc deassert in the cycle after completion, error or timeout; never both 0 then 1 inside one transfer.

Reset
REQ-031 reset: state IDLE, rdy=1, err=0, bus_req=0, bus_cyc=0, bus_wr=0, bus_addr=0, bus_wdata=0, rdata=0, watchdog=0.
REQ-032 reset mid-transfer drops bus_req/bus_cyc at the reset edge; pending bus_ack afterwards ignored.

Structure
REQ-033 Op codes (NOP/READ/WRITE/EXEC/CLEAR) and state enum live in shared package cpu_pkg for use by cpu microinstruction decode.
REQ-034 Single module, no sub-modules; watchdog is an inline counter.

Verification
REQ-035 READ addr=0x12345, gnt next cycle, ack with bus_rdata=0xAB_0123456789ABCDEF -> rdata equals it, rdy back to 1 after 3 edges.
REQ-036 WRITE wdata=0x5A_FFFF0000FFFF0000, gnt delayed 10 cycles -> bus_wr=1, bus_wdata stable, bus_cyc only after gnt, rdy=0 throughout.
REQ-037 READ with no gnt, TIMEOUT=16 -> ERR after 16 cycles, err=1, rdy=1, bus_req=0; READ ignored; CLEAR -> err=0.
REQ-038 bus_err and bus_ack both 1 in XFER -> ERR, rdata unchanged.
REQ-039 WRITE issued while READ in XFER -> ignored, bus_wr stays 0, single transfer observed.
REQ-040 reset asserted in XFER -> next cycle all bus outputs 0, rdy=1, late bus_ack changes nothing.
